// File: rtl/wb_spi_master_fifo.sv
// wb_spi_master_fifo: Wishbone-slave SPI master with TX/RX FIFOs.
//
// Supports all four SPI modes, MSB- or LSB-first frames and a programmable SCK divider
// (half-period = CLKDIV+1 clk cycles). It has one-hot active-low chip selects with an optional
// hold between transfers, and a level IRQ on TX-empty, RX-threshold or RX-overrun.
//
// Ports:
//   clk_i, rst_ni         system clock, asynchronous active-low reset
//   cyc_i, stb_i, we_i    Wishbone cycle / strobe / write enable
//   adr_i[2:0]            register word address
//   dat_i[31:0], dat_o    write / registered read data (valid with ack_o)
//   ack_o                 one-cycle acknowledge, the cycle after a request
//   sck_o, mosi_o, miso_i SPI clock, data out, data in
//   cs_no[N_CS-1:0]       active-low chip selects
//   irq_o                 registered level interrupt
//
// Register map (word address):
//   0 CTRL    [0]EN [1]CPOL [2]CPHA [3]LSB_FIRST [4]IE_TXE [5]IE_RXT [6]IE_OVR [7]LOOP
//   1 STATUS  [0]TX_EMPTY [1]TX_FULL [2]RX_EMPTY [3]RX_FULL [4]BUSY [5]OVR (write 1 clears)
//   2 DATA    write pushes TX, read pops RX (0 when empty)
//   3 CLKDIV  [15:0]
//   4 CS      [N_CS-1:0] select, [8] CS_HOLD
//   5 RXTHR   RX threshold (0 disables the threshold interrupt)
//
// Build option: define SPI_LOOPBACK_EN to enable CTRL[7] LOOP, which feeds mosi back into the
// receive sampler instead of miso_i. Without it CTRL[7] reads 0.

module wb_spi_master_fifo #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned N_CS       = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            cyc_i,
  input  logic            stb_i,
  input  logic            we_i,
  input  logic [2:0]      adr_i,
  input  logic [31:0]     dat_i,
  output logic [31:0]     dat_o,
  output logic            ack_o,
  output logic            sck_o,
  output logic            mosi_o,
  input  logic            miso_i,
  output logic [N_CS-1:0] cs_no,
  output logic            irq_o
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0]     FifoFull = CW'(FIFO_DEPTH);
  localparam logic [6:0]        LastEdge = 7'(2 * DATA_W - 1);
  localparam logic [DATA_W-1:0] TopBit   = DATA_W'(1) << (DATA_W - 1);
`ifdef SPI_LOOPBACK_EN
  localparam logic [7:0]        CtrlMask = 8'hFF;
`else
  localparam logic [7:0]        CtrlMask = 8'h7F;
`endif

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StLoad  = 2'd1;
  localparam logic [1:0] StShift = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  // Registers
  logic            ack_q;
  logic [31:0]     dat_q;
  logic [31:0]     rdata;
  logic [7:0]      ctrl_q;
  logic            ovr_q;
  logic [15:0]     clkdiv_q;
  logic [N_CS-1:0] cs_sel_q;
  logic            cs_hold_q;
  logic [CW-1:0]   rxthr_q;
  logic            irq_q;

  // FIFOs
  logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0]     tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
  logic [CW-1:0]     tx_cnt_q, rx_cnt_q;
  logic              tx_empty, tx_full, rx_empty, rx_full;
  logic              tx_push, tx_pop, rx_push, rx_pop;

  // Engine
  logic [1:0]        state_q;
  logic [15:0]       cnt_q, div_q;
  logic [6:0]        edge_q;
  logic              sck_q, mosi_q, cpha_q, lsb_q;
  logic [N_CS-1:0]   cs_q;
  logic [DATA_W-1:0] tx_sh_q, rx_sh_q, tx_head;
  logic              busy, half_done, sample, rx_push_req, ovr_set, din, en;

  logic bus_req, bus_wr, bus_rd;
  logic unused_dat;

  assign unused_dat = ^dat_i[31:16];

  assign bus_req = cyc_i & stb_i & ~ack_q;
  assign bus_wr  = bus_req & we_i;
  assign bus_rd  = bus_req & ~we_i;
  assign en      = ctrl_q[0];

  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == FifoFull);
  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == FifoFull);

  assign tx_push = bus_wr & (adr_i == 3'd2) & ~tx_full;
  assign rx_pop  = bus_rd & (adr_i == 3'd2) & ~rx_empty;
  assign tx_pop  = (state_q == StLoad);
  assign tx_head = tx_mem[tx_rd_q];

  assign busy        = (state_q != StIdle);
  assign half_done   = (cnt_q == div_q);
  // Even edge index is the leading edge; CPHA selects which edge samples.
  assign sample      = ~edge_q[0] ^ cpha_q;
  // Push on the first DONE cycle so the final sample has landed in rx_sh_q.
  assign rx_push_req = (state_q == StDone) & (cnt_q == '0);
  assign rx_push     = rx_push_req & ~rx_full;
  assign ovr_set     = rx_push_req & rx_full;

`ifdef SPI_LOOPBACK_EN
  assign din = ctrl_q[7] ? mosi_q : miso_i;
`else
  assign din = miso_i;
`endif

  function automatic logic first_bit(logic [DATA_W-1:0] d, logic lsb);
    return lsb ? d[0] : d[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(logic [DATA_W-1:0] d, logic lsb);
    return lsb ? (d >> 1) : (d << 1);
  endfunction

  function automatic logic [DATA_W-1:0] sample_in(logic [DATA_W-1:0] d, logic lsb, logic b);
    return lsb ? ((d >> 1) | (b ? TopBit : '0)) : ((d << 1) | DATA_W'(b));
  endfunction

  // Register read mux
  always_comb begin
    rdata = '0;
    case (adr_i)
      3'd0: rdata[7:0] = ctrl_q;
      3'd1: rdata[5:0] = {ovr_q, busy, rx_full, rx_empty, tx_full, tx_empty};
      3'd2: if (!rx_empty) rdata[DATA_W-1:0] = rx_mem[rx_rd_q];
      3'd3: rdata[15:0] = clkdiv_q;
      3'd4: begin
        rdata[N_CS-1:0] = cs_sel_q;
        rdata[8]        = cs_hold_q;
      end
      3'd5: rdata[CW-1:0] = rxthr_q;
      default: ;
    endcase
  end

  // Bus interface and control registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_q     <= 1'b0;
      dat_q     <= '0;
      ctrl_q    <= '0;
      ovr_q     <= 1'b0;
      clkdiv_q  <= '0;
      cs_sel_q  <= '0;
      cs_hold_q <= 1'b0;
      rxthr_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      ack_q <= bus_req;
      dat_q <= bus_rd ? rdata : '0;
      if (bus_wr) begin
        case (adr_i)
          3'd0: ctrl_q <= dat_i[7:0] & CtrlMask;
          3'd3: clkdiv_q <= dat_i[15:0];
          3'd4: begin
            cs_sel_q  <= dat_i[N_CS-1:0];
            cs_hold_q <= dat_i[8];
          end
          3'd5: rxthr_q <= dat_i[CW-1:0];
          default: ;
        endcase
      end
      // A new overrun wins over a simultaneous clear.
      if (ovr_set) begin
        ovr_q <= 1'b1;
      end else if (bus_wr && adr_i == 3'd1 && dat_i[5]) begin
        ovr_q <= 1'b0;
      end
      irq_q <= (ctrl_q[4] & tx_empty & ~busy) |
               (ctrl_q[5] & (rx_cnt_q >= rxthr_q) & (rxthr_q != '0)) |
               (ctrl_q[6] & ovr_q);
    end
  end

  // FIFO storage, no reset needed
  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem[tx_wr_q] <= dat_i[DATA_W-1:0];
    if (rx_push) rx_mem[rx_wr_q] <= rx_sh_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_cnt_q <= '0;
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (tx_push) tx_wr_q <= tx_wr_q + 1'b1;
      if (tx_pop)  tx_rd_q <= tx_rd_q + 1'b1;
      if (rx_push) rx_wr_q <= rx_wr_q + 1'b1;
      if (rx_pop)  rx_rd_q <= rx_rd_q + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt_q <= tx_cnt_q + 1'b1;
        2'b01:   tx_cnt_q <= tx_cnt_q - 1'b1;
        default: ;
      endcase
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt_q <= rx_cnt_q + 1'b1;
        2'b01:   rx_cnt_q <= rx_cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  // SPI engine. Mode, bit order and divider are latched in LOAD so mid-frame
  // register writes only affect the next frame.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      div_q   <= '0;
      edge_q  <= '0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
      cs_q    <= '1;
      tx_sh_q <= '0;
      rx_sh_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          sck_q <= ctrl_q[1];
          if (!cs_hold_q) cs_q <= '1;
          if (en && !tx_empty) state_q <= StLoad;
        end
        StLoad: begin
          state_q <= StShift;
          cnt_q   <= '0;
          edge_q  <= '0;
          div_q   <= clkdiv_q;
          cpha_q  <= ctrl_q[2];
          lsb_q   <= ctrl_q[3];
          sck_q   <= ctrl_q[1];
          cs_q    <= ~cs_sel_q;
          rx_sh_q <= '0;
          // CPHA=0 needs the first bit on MOSI before the first leading edge.
          if (ctrl_q[2]) begin
            tx_sh_q <= tx_head;
          end else begin
            mosi_q  <= first_bit(tx_head, ctrl_q[3]);
            tx_sh_q <= shift_out(tx_head, ctrl_q[3]);
          end
        end
        StShift: begin
          if (half_done) begin
            cnt_q  <= '0;
            sck_q  <= ~sck_q;
            edge_q <= edge_q + 7'd1;
            if (sample) begin
              rx_sh_q <= sample_in(rx_sh_q, lsb_q, din);
            end else begin
              mosi_q  <= first_bit(tx_sh_q, lsb_q);
              tx_sh_q <= shift_out(tx_sh_q, lsb_q);
            end
            if (edge_q == LastEdge) state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        StDone: begin
          if (half_done) begin
            cnt_q <= '0;
            if (en && !tx_empty) begin
              state_q <= StLoad;
            end else begin
              state_q <= StIdle;
              if (!cs_hold_q) cs_q <= '1;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ack_o  = ack_q;
  assign dat_o  = dat_q;
  assign sck_o  = sck_q;
  assign mosi_o = mosi_q;
  assign cs_no  = cs_q;
  assign irq_o  = irq_q;

endmodule

// File: tb/tb_wb_spi_master_fifo.sv
// Directed bench for wb_spi_master_fifo (DATA_W=8, FIFO_DEPTH=8, N_CS=1) with an SPI slave model.
module tb_wb_spi_master_fifo;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        cyc_i, stb_i, we_i;
  logic [2:0]  adr_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        ack_o;
  logic        sck_o, mosi_o, miso_i;
  logic [0:0]  cs_no;
  logic        irq_o;

  int n_chk  = 0;
  int n_pass = 0;

  wb_spi_master_fifo #(.DATA_W(8), .FIFO_DEPTH(8), .N_CS(1)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .cyc_i  (cyc_i),
    .stb_i  (stb_i),
    .we_i   (we_i),
    .adr_i  (adr_i),
    .dat_i  (dat_i),
    .dat_o  (dat_o),
    .ack_o  (ack_o),
    .sck_o  (sck_o),
    .mosi_o (mosi_o),
    .miso_i (miso_i),
    .cs_no  (cs_no),
    .irq_o  (irq_o)
  );

  always #5 clk_i = ~clk_i;

  // SPI slave model
  logic       s_cpol = 0, s_cpha = 0, s_lsb = 0;
  logic [7:0] s_tx = 8'h00;
  logic [7:0] s_rx;
  int         s_bits, s_sent;
  logic [7:0] s_q[$];
  int         n_cs_fall = 0;
  int         n_lead = 0;
  time        t_lead1, t_lead2;

  function automatic logic s_bit(input int i);
    logic [7:0] v;
    v = s_tx;
    return s_lsb ? v[i] : v[7-i];
  endfunction

  always @(negedge cs_no[0]) begin
    s_sent = 0;
    s_bits = 0;
    s_rx   = 8'h00;
    n_cs_fall++;
    if (!s_cpha) begin
      miso_i = s_bit(0);
      s_sent = 1;
    end
  end

  always @(sck_o) begin
    logic lead;
    if (cs_no[0] === 1'b0) begin
      lead = (sck_o != s_cpol);
      if (lead) begin
        n_lead++;
        if (n_lead == 1) t_lead1 = $time;
        if (n_lead == 2) t_lead2 = $time;
      end
      if (lead ^ s_cpha) begin
        if (s_lsb) s_rx[s_bits] = mosi_o;
        else s_rx = {s_rx[6:0], mosi_o};
        s_bits++;
        if (s_bits == 8) begin
          s_q.push_back(s_rx);
          s_bits = 0;
          s_rx   = 8'h00;
        end
      end else begin
        miso_i = s_bit(s_sent % 8);
        s_sent++;
      end
    end
  end

  task automatic slave_mode(input logic cpol, input logic cpha, input logic lsb,
                            input logic [7:0] tx);
    s_cpol = cpol;
    s_cpha = cpha;
    s_lsb  = lsb;
    s_tx   = tx;
    s_q.delete();
  endtask

  task automatic wb_write(input logic [2:0] a, input logic [31:0] d);
    bit got;
    @(posedge clk_i); #1;
    cyc_i = 1; stb_i = 1; we_i = 1; adr_i = a; dat_i = d;
    got = 0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk_i); #1;
      if (ack_o) got = 1;
    end
    cyc_i = 0; stb_i = 0; we_i = 0;
    if (!got) begin
      n_chk++;
      $display("FAIL wb_write_ack: adr=%0d no ack within 4 cycles", a);
    end
  endtask

  task automatic wb_read(input logic [2:0] a, output logic [31:0] d);
    bit got;
    @(posedge clk_i); #1;
    cyc_i = 1; stb_i = 1; we_i = 0; adr_i = a;
    got = 0;
    d = 'x;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk_i); #1;
      if (ack_o) begin
        got = 1;
        d = dat_o;
      end
    end
    cyc_i = 0; stb_i = 0;
    if (!got) begin
      n_chk++;
      $display("FAIL wb_read_ack: adr=%0d no ack within 4 cycles", a);
    end
  endtask

  // Poll STATUS until TX empty and not busy.
  task automatic wait_idle(input int max_polls);
    logic [31:0] st;
    bit done;
    done = 0;
    for (int i = 0; i < max_polls && !done; i++) begin
      wb_read(3'd1, st);
      if (st[4] == 1'b0 && st[0] == 1'b1) done = 1;
    end
    if (!done) begin
      n_chk++;
      $display("FAIL wait_idle: engine still busy after %0d polls", max_polls);
    end
  endtask

  task automatic test_reset;
    logic [31:0] r;
    n_chk++;
    if ({ack_o, dat_o, sck_o, mosi_o, cs_no, irq_o} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      $display("FAIL reset_outputs: got ack=%b dat=%h sck=%b mosi=%b cs=%b irq=%b want 0,0,0,0,1,0",
               ack_o, dat_o, sck_o, mosi_o, cs_no, irq_o);
    end else n_pass++;
    @(negedge clk_i); rst_ni = 1;
    wb_read(3'd1, r);
    n_chk++;
    if (r !== 32'h05) $display("FAIL reset_status: got %h want 00000005", r); else n_pass++;
    wb_read(3'd0, r);
    n_chk++;
    if (r !== 32'h0) $display("FAIL reset_ctrl: got %h want 0", r); else n_pass++;
    wb_write(3'd6, 32'hFFFF_FFFF);
    wb_read(3'd6, r);
    n_chk++;
    if (r !== 32'h0) $display("FAIL reg6_read: got %h want 0", r); else n_pass++;
    wb_write(3'd0, 32'h80);
    wb_read(3'd0, r);
    n_chk++;
`ifdef SPI_LOOPBACK_EN
    if (r !== 32'h80) $display("FAIL ctrl_loop_bit: got %h want 80", r); else n_pass++;
`else
    if (r !== 32'h00) $display("FAIL ctrl_loop_bit: got %h want 0", r); else n_pass++;
`endif
    wb_write(3'd0, 32'h0);
  endtask

  task automatic test_mode0;
    logic [31:0] r;
    slave_mode(0, 0, 0, 8'h3C);
    wb_write(3'd3, 32'd1);
    wb_write(3'd4, 32'h1);
    wb_write(3'd0, 32'h01);
    n_lead = 0;
    wb_write(3'd2, 32'hA5);
    wait_idle(100);
    n_chk++;
    if (s_q.size() != 1 || s_q[0] !== 8'hA5)
      $display("FAIL mode0_mosi: got %0d frames first=%h want 1 frame a5", s_q.size(),
               (s_q.size() > 0) ? s_q[0] : 8'hxx);
    else n_pass++;
    n_chk++;
    if (n_lead != 8) $display("FAIL mode0_sck_count: got %0d want 8", n_lead); else n_pass++;
    n_chk++;
    if (t_lead2 - t_lead1 != 40) $display("FAIL mode0_sck_period: got %0t want 40", t_lead2 - t_lead1);
    else n_pass++;
    wb_read(3'd2, r);
    n_chk++;
    if (r !== 32'h3C) $display("FAIL mode0_rx: got %h want 3c", r); else n_pass++;
    n_chk++;
    if (cs_no !== 1'b1) $display("FAIL mode0_cs_release: got %b want 1", cs_no); else n_pass++;
  endtask

  task automatic test_modes;
    logic [31:0] r;
    logic [7:0]  want;
    for (int m = 1; m < 4; m++) begin
      want = 8'h40 + 8'(m);
      slave_mode(m[1], m[0], 0, want);
      wb_write(3'd0, 32'h01 | (32'(m[1]) << 1) | (32'(m[0]) << 2));
      repeat (2) @(posedge clk_i);
      #1;
      n_chk++;
      if (sck_o !== m[1]) $display("FAIL mode%0d_sck_idle: got %b want %b", m, sck_o, m[1]);
      else n_pass++;
      wb_write(3'd2, 32'h81);
      wait_idle(100);
      n_chk++;
      if (s_q.size() != 1 || s_q[0] !== 8'h81)
        $display("FAIL mode%0d_tx: got %0d frames first=%h want 81", m, s_q.size(),
                 (s_q.size() > 0) ? s_q[0] : 8'hxx);
      else n_pass++;
      wb_read(3'd2, r);
      n_chk++;
      if (r !== 32'(want)) $display("FAIL mode%0d_rx: got %h want %h", m, r, want); else n_pass++;
    end
    // LSB first, mode 0
    slave_mode(0, 0, 1, 8'h12);
    wb_write(3'd0, 32'h09);
    wb_write(3'd2, 32'h0F);
    wait_idle(100);
    n_chk++;
    if (s_q.size() != 1 || s_q[0] !== 8'h0F)
      $display("FAIL lsb_tx: got %0d frames first=%h want 0f", s_q.size(),
               (s_q.size() > 0) ? s_q[0] : 8'hxx);
    else n_pass++;
    wb_read(3'd2, r);
    n_chk++;
    if (r !== 32'h12) $display("FAIL lsb_rx: got %h want 12", r); else n_pass++;
  endtask

  task automatic test_fifo;
    logic [31:0] r;
    bit ok;
    slave_mode(0, 0, 0, 8'h3C);
    wb_write(3'd0, 32'h00);
    for (int i = 0; i < 9; i++) wb_write(3'd2, 32'h10 + 32'(i));
    wb_read(3'd1, r);
    n_chk++;
    if (r !== 32'h06) $display("FAIL fifo_tx_full: status got %h want 06", r); else n_pass++;
    n_cs_fall = 0;
    wb_write(3'd0, 32'h01);
    wait_idle(400);
    n_chk++;
    if (n_cs_fall != 1) $display("FAIL b2b_cs_low: cs falls got %0d want 1", n_cs_fall);
    else n_pass++;
    ok = (s_q.size() == 8);
    for (int i = 0; i < 8 && ok; i++) if (s_q[i] !== 8'h10 + 8'(i)) ok = 0;
    n_chk++;
    if (!ok) $display("FAIL b2b_frames: got %0d frames want 8 of 10..17", s_q.size());
    else n_pass++;
    wb_read(3'd1, r);
    n_chk++;
    if (r !== 32'h09) $display("FAIL fifo_rx_full: status got %h want 09", r); else n_pass++;
    ok = 1;
    for (int i = 0; i < 8; i++) begin
      wb_read(3'd2, r);
      if (r !== 32'h3C) ok = 0;
    end
    n_chk++;
    if (!ok) $display("FAIL fifo_drain: some rx word got %h want 3c", r); else n_pass++;
    wb_read(3'd2, r);
    n_chk++;
    if (r !== 32'h0) $display("FAIL rx_empty_read: got %h want 0", r); else n_pass++;
  endtask

  task automatic test_overrun;
    logic [31:0] r;
    slave_mode(0, 0, 0, 8'h77);
    wb_write(3'd0, 32'h41);
    for (int i = 0; i < 9; i++) wb_write(3'd2, 32'h20 + 32'(i));
    wait_idle(500);
    wb_read(3'd1, r);
    n_chk++;
    if (r !== 32'h29) $display("FAIL ovr_status: got %h want 29", r); else n_pass++;
    n_chk++;
    if (irq_o !== 1'b1) $display("FAIL ovr_irq: got %b want 1", irq_o); else n_pass++;
    wb_write(3'd1, 32'h20);
    repeat (2) @(posedge clk_i);
    #1;
    n_chk++;
    if (irq_o !== 1'b0) $display("FAIL ovr_irq_clear: got %b want 0", irq_o); else n_pass++;
    wb_read(3'd1, r);
    n_chk++;
    if (r !== 32'h09) $display("FAIL ovr_w1c: status got %h want 09", r); else n_pass++;
    for (int i = 0; i < 8; i++) wb_read(3'd2, r);
    wb_read(3'd1, r);
    n_chk++;
    if (r !== 32'h05) $display("FAIL ovr_drained: status got %h want 05", r); else n_pass++;
  endtask

  task automatic test_irq;
    logic [31:0] r;
    slave_mode(0, 0, 0, 8'h11);
    wb_write(3'd0, 32'h11);
    repeat (2) @(posedge clk_i);
    #1;
    n_chk++;
    if (irq_o !== 1'b1) $display("FAIL irq_txe: got %b want 1", irq_o); else n_pass++;
    wb_write(3'd5, 32'd2);
    wb_write(3'd0, 32'h21);
    wb_write(3'd2, 32'h01);
    wait_idle(100);
    repeat (2) @(posedge clk_i);
    #1;
    n_chk++;
    if (irq_o !== 1'b0) $display("FAIL irq_rxt_below: got %b want 0", irq_o); else n_pass++;
    wb_write(3'd2, 32'h02);
    wait_idle(100);
    repeat (2) @(posedge clk_i);
    #1;
    n_chk++;
    if (irq_o !== 1'b1) $display("FAIL irq_rxt_at: got %b want 1", irq_o); else n_pass++;
    wb_read(3'd2, r);
    repeat (2) @(posedge clk_i);
    #1;
    n_chk++;
    if (irq_o !== 1'b0) $display("FAIL irq_rxt_after_pop: got %b want 0", irq_o); else n_pass++;
    wb_write(3'd5, 32'd0);
    repeat (2) @(posedge clk_i);
    #1;
    n_chk++;
    if (irq_o !== 1'b0) $display("FAIL irq_rxt_zero: got %b want 0", irq_o); else n_pass++;
    wb_read(3'd2, r);
    wb_write(3'd0, 32'h01);
  endtask

`ifdef SPI_LOOPBACK_EN
  task automatic test_loopback;
    logic [31:0] r;
    slave_mode(0, 0, 0, 8'h00);
    miso_i = 0;
    wb_write(3'd5, 32'd1);
    wb_write(3'd0, 32'hA1);
    wb_write(3'd2, 32'h5A);
    wait_idle(100);
    repeat (2) @(posedge clk_i);
    #1;
    n_chk++;
    if (irq_o !== 1'b1) $display("FAIL loop_irq_rxt: got %b want 1", irq_o); else n_pass++;
    wb_read(3'd2, r);
    n_chk++;
    if (r !== 32'h5A) $display("FAIL loop_rx: got %h want 5a", r); else n_pass++;
    wb_write(3'd5, 32'd0);
    wb_write(3'd0, 32'h01);
  endtask
`endif

  task automatic test_reset_mid_frame;
    logic [31:0] r;
    slave_mode(0, 0, 0, 8'h00);
    wb_write(3'd3, 32'd20);
    wb_write(3'd0, 32'h01);
    wb_write(3'd2, 32'h55);
    repeat (30) @(posedge clk_i);
    @(negedge clk_i);
    n_chk++;
    if (cs_no !== 1'b0 || sck_o !== 1'b1)
      $display("FAIL midframe_pre: got cs=%b sck=%b want 0,1", cs_no, sck_o);
    else n_pass++;
    #2 rst_ni = 0;
    #1;
    n_chk++;
    if ({cs_no, sck_o, mosi_o, irq_o, ack_o} !== 5'b10000)
      $display("FAIL midframe_reset: got cs=%b sck=%b mosi=%b irq=%b ack=%b want 1,0,0,0,0",
               cs_no, sck_o, mosi_o, irq_o, ack_o);
    else n_pass++;
    @(negedge clk_i); rst_ni = 1;
    wb_read(3'd1, r);
    n_chk++;
    if (r !== 32'h05) $display("FAIL midframe_status: got %h want 05", r); else n_pass++;
  endtask

  initial begin
    rst_ni = 0;
    cyc_i = 0; stb_i = 0; we_i = 0; adr_i = '0; dat_i = '0; miso_i = 0;
    repeat (3) @(posedge clk_i);
    #1;
    test_reset;
    test_mode0;
    test_modes;
    test_fifo;
    test_overrun;
    test_irq;
`ifdef SPI_LOOPBACK_EN
    test_loopback;
`endif
    test_reset_mid_frame;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
